centroid_norm_sched: RTL and testbench
======================================

// Module: centroid_norm_sched
// PURPOSE
//  Per-iteration sequencer for the centroid half-norm unit (||c||^2/2 per cluster).
//  On start: clears the norm unit, streams every centroid from the centroid buffer in NUM_BANK-word chunks, then waits for the norm result.
//  Signals done/error to the k-means iteration controller.
//  Sits between the centroid buffer read port and the norm unit's chunk input.
// PARAMETERS
//  NUM_BANK         8     32-bit words per chunk (buffer read width = NUM_BANK*32)
//  MAX_DEPTH_BITS   9     data_dim width - 1
//  NUM_CLUSTER_BITS 4     num_cluster width - 1
//  ADDR_BITS        12    centroid buffer chunk-address width
//  RD_LAT           2     buffer read latency in cycles (>=1)
//  TIMEOUT          1024  max cycles in WAIT_NORM before error
// PORTS
//  clk               in   1                  clock; single clock domain
//  rst               in   1                  synchronous reset, active-high
//  data_dim          in   MAX_DEPTH_BITS+1   dimensions per centroid; sampled on accepted start
//  num_cluster       in   NUM_CLUSTER_BITS+1 centroid count; sampled on accepted start
//  start             in   1                  begin pass; accepted only in IDLE
//  busy              out  1                  high in every state except IDLE
//  done              out  1                  1-cycle pulse: pass finished OK
//  error             out  1                  1-cycle pulse: norm timeout
//  mem_wr_busy       in   1                  buffer being updated; stalls reads
//  mem_rd_en         out  1                  buffer read strobe
//  mem_rd_addr       out  ADDR_BITS          chunk address
//  mem_rd_data       in   NUM_BANK*32        read data, RD_LAT cycles after mem_rd_en
//  norm_rst_n_o      out  1                  active-low clear to the norm unit
//  centroid_chunk_o  out  NUM_BANK*32        chunk to the norm unit
//  centroid_chunk_valid_o out 1              chunk qualifier
//  norm_valid_i      in   1                  norm unit result valid
// BEHAVIOUR
//  Reset: FSM=IDLE; busy=done=error=mem_rd_en=centroid_chunk_valid_o=0; mem_rd_addr=0; norm_rst_n_o=0.
//  Reset holds norm_rst_n_o low throughout; it is released the cycle after reset deasserts.
//  Config at start: chunks = ceil(data_dim/NUM_BANK); total = chunks*num_cluster, ADDR_BITS wide, truncated.
//  IDLE -> CLR on start. In IDLE, norm_rst_n_o=1.
//  Start in IDLE with num_cluster==0 or data_dim==0: no reads; done pulses in the next cycle; FSM stays IDLE.
//  CLR: norm_rst_n_o=0 for exactly 2 cycles, then 1 idle cycle (norm unit re-registers its reset) -> READ.
//  READ: one mem_rd_en per cycle, addr 0..total-1, linear and incrementing.
//   mem_wr_busy=1 in READ: mem_rd_en=0, addr held; resume at the same addr when mem_wr_busy falls.
//   Issue of addr total-1 -> DRAIN.
//  DRAIN: wait until all in-flight reads return -> WAIT_NORM.
//   A RD_LAT-deep valid shift register tracks in-flight reads.
//  Chunk output: centroid_chunk_o=mem_rd_data and valid=shift-register tap, RD_LAT after each mem_rd_en.
//   Valid gaps mirror stalls. Exactly total valid chunks are delivered per pass.
//  WAIT_NORM: timeout counter starts at 0. norm_valid_i -> DONE.
//   Counter reaches TIMEOUT-1 without norm_valid_i -> ERR.
//  DONE: done=1 for one cycle -> IDLE. ERR: error=1 for one cycle -> IDLE.
//  busy=1 in CLR, READ, DRAIN, WAIT_NORM, DONE, ERR.
//  Start while busy: ignored; config is not re-sampled.
//  norm_valid_i outside WAIT_NORM: ignored. A same-cycle timeout and norm_valid_i resolve to DONE.
//  rst mid-pass aborts at once: in-flight read data is discarded and no done is produced.
//   The next pass re-clears the norm unit.
//  Input changes on data_dim/num_cluster while busy have no effect.
// TESTING
//  NB=8, dim=16, k=4, RD_LAT=2: addr 0..7 on 8 consecutive cycles; 8 chunk valids 2 cycles later; single norm_valid -> done 1 cycle later.
//  dim=10, k=3: chunks=2, total=6; addr 0..5 only; norm_rst_n_o low exactly 2 cycles after start.
//  mem_wr_busy high 3 cycles mid-READ at addr 4: addr 4 held, no rd_en for 3 cycles; all 8 chunks delivered in order.
//  norm_valid_i never asserted, TIMEOUT=16: error pulses 16 cycles after WAIT_NORM entry; done never; busy drops.
//  k=0: done pulses 1 cycle after start; mem_rd_en and norm_rst_n_o never toggle. Second start during busy: ignored.
//  rst asserted in READ at addr 3: all outputs return to reset values next cycle; no late chunk valid.
//   A fresh start completes normally.

Source files
------------

// File: rtl/centroid_norm_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : centroid_norm_sched
//  Purpose  : Per-iteration sequencer that clears the centroid half-norm unit,
//             streams every centroid chunk from the buffer, and awaits the result.
//  Revision : 1.0
// ============================================================================
module centroid_norm_sched #(
    parameter int NUM_BANK         = 8,
    parameter int MAX_DEPTH_BITS   = 9,
    parameter int NUM_CLUSTER_BITS = 4,
    parameter int ADDR_BITS        = 12,
    parameter int RD_LAT           = 2,
    parameter int TIMEOUT          = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_DEPTH_BITS:0]     data_dim,
    input  logic [NUM_CLUSTER_BITS:0]   num_cluster,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    input  logic                        mem_wr_busy,
    output logic                        mem_rd_en,
    output logic [ADDR_BITS-1:0]        mem_rd_addr,
    input  logic [NUM_BANK*32-1:0]      mem_rd_data,
    output logic                        norm_rst_n_o,
    output logic [NUM_BANK*32-1:0]      centroid_chunk_o,
    output logic                        centroid_chunk_valid_o,
    input  logic                        norm_valid_i
);

    localparam int c_dim_w = MAX_DEPTH_BITS + 2;
    localparam int c_to_w  = $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_last     = c_to_w'(TIMEOUT - 1);
    // Every in-flight bit except the oldest, which is on the output this cycle.
    localparam logic [RD_LAT-1:0] c_vld_pending = RD_LAT'((1 << (RD_LAT - 1)) - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t                 r_state;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   r_last;
    logic [1:0]             r_clr_cnt;
    logic [c_to_w-1:0]      r_to_cnt;
    logic [RD_LAT-1:0]      r_vld;

    logic [c_dim_w-1:0]     w_chunks;
    logic [ADDR_BITS-1:0]   w_total;
    logic                   w_zero_cfg;
    logic                   w_rd_en;

    // Product is taken modulo 2^ADDR_BITS, matching the truncated total.
    assign w_chunks   = ({1'b0, data_dim} + c_dim_w'(NUM_BANK - 1)) / c_dim_w'(NUM_BANK);
    assign w_total    = ADDR_BITS'(w_chunks) * ADDR_BITS'(num_cluster);
    assign w_zero_cfg = (data_dim == '0) || (num_cluster == '0);
    assign w_rd_en    = (r_state == S_READ) && !mem_wr_busy;

    assign mem_rd_en              = w_rd_en;
    assign mem_rd_addr            = r_addr;
    assign centroid_chunk_o       = mem_rd_data;
    assign centroid_chunk_valid_o = r_vld[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            norm_rst_n_o <= 1'b0;
            r_addr       <= '0;
            r_last       <= '0;
            r_clr_cnt    <= '0;
            r_to_cnt     <= '0;
            r_vld        <= '0;
        end else begin
            r_vld <= (r_vld << 1) | RD_LAT'(w_rd_en);
            done  <= 1'b0;
            error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    norm_rst_n_o <= 1'b1;
                    if (start) begin
                        if (w_zero_cfg) begin
                            done <= 1'b1;
                        end else begin
                            r_state      <= S_CLR;
                            busy         <= 1'b1;
                            norm_rst_n_o <= 1'b0;
                            r_clr_cnt    <= '0;
                            r_addr       <= '0;
                            r_last       <= w_total - ADDR_BITS'(1);
                        end
                    end
                end
                // Two cycles of clear, then one settle cycle before reading.
                S_CLR: begin
                    if (r_clr_cnt == 2'd0) begin
                        r_clr_cnt <= 2'd1;
                    end else if (r_clr_cnt == 2'd1) begin
                        r_clr_cnt    <= 2'd2;
                        norm_rst_n_o <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_rd_en) begin
                        if (r_addr == r_last) begin
                            r_state <= S_DRAIN;
                            r_addr  <= '0;
                        end else begin
                            r_addr <= r_addr + ADDR_BITS'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_vld & c_vld_pending) == '0) begin
                        r_state  <= S_WAIT;
                        r_to_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (norm_valid_i) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if (r_to_cnt == c_to_last) begin
                        r_state <= S_ERR;
                        error   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_to_w'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_centroid_norm_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_centroid_norm_sched
//  Purpose  : Directed and randomized checks of centroid_norm_sched against a
//             cycle-level behavioural model of a pass.
//  Revision : 1.0
// ============================================================================
module tb_centroid_norm_sched;

    localparam int NB        = 8;
    localparam int RD_LAT    = 2;
    localparam int TIMEOUT   = 16;
    localparam int ADDR_BITS = 12;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [9:0]             data_dim = '0;
    logic [4:0]             num_cluster = '0;
    logic                   start = 1'b0;
    logic                   busy, done, error;
    logic                   mem_wr_busy = 1'b0;
    logic                   mem_rd_en;
    logic [ADDR_BITS-1:0]   mem_rd_addr;
    logic [NB*32-1:0]       mem_rd_data;
    logic                   norm_rst_n_o;
    logic [NB*32-1:0]       centroid_chunk_o;
    logic                   centroid_chunk_valid_o;
    logic                   norm_valid_i = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    centroid_norm_sched #(
        .NUM_BANK(NB), .MAX_DEPTH_BITS(9), .NUM_CLUSTER_BITS(4),
        .ADDR_BITS(ADDR_BITS), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .data_dim(data_dim), .num_cluster(num_cluster),
        .start(start), .busy(busy), .done(done), .error(error),
        .mem_wr_busy(mem_wr_busy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .norm_rst_n_o(norm_rst_n_o),
        .centroid_chunk_o(centroid_chunk_o),
        .centroid_chunk_valid_o(centroid_chunk_valid_o),
        .norm_valid_i(norm_valid_i)
    );

    function automatic logic [255:0] chunk_of(input logic [7:0] s, input logic [11:0] a);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < NB; j++) r[j*32 +: 32] = {s, a, 4'(j), 8'hA5};
        return r;
    endfunction

    // Buffer model: data for an address appears RD_LAT cycles after its read strobe.
    logic [7:0]           salt = 8'h00;
    logic [RD_LAT-1:0]    p_v = '0;
    logic [ADDR_BITS-1:0] p_a [RD_LAT];
    logic [255:0]         junk = '0;

    always @(posedge clk) begin
        p_v     <= {p_v[RD_LAT-2:0], mem_rd_en};
        p_a[0]  <= mem_rd_addr;
        for (int i = 1; i < RD_LAT; i++) p_a[i] <= p_a[i-1];
        junk    <= {8{$urandom}};
    end

    assign mem_rd_data = p_v[RD_LAT-1] ? chunk_of(salt, p_a[RD_LAT-1]) : junk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full pass. Cycle 0 carries start; nv_delay<0 means no norm result.
    task automatic run_pass(input int dim, input int k, input int stall_pct,
                            input int stall_at, input int nv_delay, input bit early_nv);
        int  total, issued, got, wait_c, end_c, st_cnt;
        bit  zero, is_err, phase, exp_rd, exp_v, finished;
        int  q_iss[$];
        total    = (((dim + NB - 1) / NB) * k) % 4096;
        zero     = (dim == 0) || (k == 0);
        is_err   = !zero && ((nv_delay < 0) || (nv_delay >= TIMEOUT));
        issued   = 0;
        got      = 0;
        wait_c   = -1;
        st_cnt   = 0;
        finished = 1'b0;
        end_c    = zero ? 1 : -1;
        @(posedge clk); #1;
        salt         = 8'($urandom);
        start        = 1'b1;
        data_dim     = 10'(dim);
        num_cluster  = 5'(k);
        mem_wr_busy  = 1'b0;
        norm_valid_i = 1'b0;
        #1;
        chk("idle_busy", 256'(busy), 256'(0));
        for (int c = 1; c < 600 && !finished; c++) begin
            @(posedge clk); #1;
            start       = !zero && (c == 2);
            data_dim    = 10'($urandom);
            num_cluster = 5'($urandom);
            phase       = !zero && (c >= 4) && (issued < total);
            mem_wr_busy = ($urandom_range(99) < stall_pct);
            if (stall_at >= 0 && phase && issued == stall_at && st_cnt < 3) begin
                mem_wr_busy = 1'b1;
                st_cnt++;
            end
            norm_valid_i = (early_nv && c == 3) ||
                           (wait_c >= 0 && nv_delay >= 0 && c == wait_c + nv_delay);
            #1;
            exp_rd = phase && !mem_wr_busy;
            chk("rd_en", 256'(mem_rd_en), 256'(exp_rd));
            if (phase && mem_wr_busy) chk("hold_addr", 256'(mem_rd_addr), 256'(issued));
            if (exp_rd) begin
                chk("rd_addr", 256'(mem_rd_addr), 256'(issued));
                q_iss.push_back(c);
                issued++;
            end
            chk("norm_rst_n", 256'(norm_rst_n_o), 256'(!(!zero && (c == 1 || c == 2))));
            exp_v = (q_iss.size() > 0) && (q_iss[0] == c - RD_LAT);
            chk("chunk_valid", 256'(centroid_chunk_valid_o), 256'(exp_v));
            if (exp_v) begin
                chk("chunk_data", centroid_chunk_o, chunk_of(salt, 12'(got)));
                void'(q_iss.pop_front());
                got++;
                if (got == total) begin
                    wait_c = c + 1;
                    end_c  = is_err ? wait_c + TIMEOUT : wait_c + nv_delay + 1;
                end
            end
            chk("done", 256'(done), 256'(c == end_c && !is_err));
            chk("error", 256'(error), 256'(c == end_c && is_err));
            chk("busy", 256'(busy), 256'(!zero && (end_c < 0 || c <= end_c)));
            if (end_c >= 0 && c >= end_c + 2) finished = 1'b1;
        end
        start        = 1'b0;
        norm_valid_i = 1'b0;
        chk("pass_complete", 256'(finished), 256'(1));
        chk("chunk_count", 256'(got), 256'(total));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_error", 256'(error), 256'(0));
        chk("rst_rd_en", 256'(mem_rd_en), 256'(0));
        chk("rst_addr", 256'(mem_rd_addr), 256'(0));
        chk("rst_valid", 256'(centroid_chunk_valid_o), 256'(0));
        chk("rst_norm_rst_n", 256'(norm_rst_n_o), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release", 256'(norm_rst_n_o), 256'(1));

        run_pass(16, 4, 0, -1, 3, 1'b0);    // baseline 8 chunks
        run_pass(10, 3, 0, -1, 0, 1'b1);    // 6 chunks, early norm_valid ignored
        run_pass(16, 4, 0, 4, 1, 1'b0);     // 3-cycle write stall at addr 4
        run_pass(16, 4, 0, -1, -1, 1'b0);   // timeout
        run_pass(9, 2, 0, -1, TIMEOUT - 1, 1'b0);  // result on the timeout cycle
        run_pass(8, 1, 0, -1, TIMEOUT, 1'b0);      // result one cycle too late
        run_pass(12, 0, 0, -1, 0, 1'b0);    // k = 0
        run_pass(0, 5, 0, -1, 0, 1'b0);     // dim = 0

        // Reset in the middle of READ while addr 3 is issued.
        @(posedge clk); #1;
        salt         = 8'($urandom);
        start        = 1'b1;
        data_dim     = 10'd16;
        num_cluster  = 5'd4;
        mem_wr_busy  = 1'b0;
        norm_valid_i = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = (c == 7);
            #1;
            if (c >= 4 && c <= 7) chk("abort_addr", 256'(mem_rd_addr), 256'(c - 4));
            if (c == 8) begin
                chk("abort_busy", 256'(busy), 256'(0));
                chk("abort_rd_en", 256'(mem_rd_en), 256'(0));
                chk("abort_addr0", 256'(mem_rd_addr), 256'(0));
                chk("abort_valid", 256'(centroid_chunk_valid_o), 256'(0));
                chk("abort_done", 256'(done), 256'(0));
                chk("abort_error", 256'(error), 256'(0));
                chk("abort_norm_rst_n", 256'(norm_rst_n_o), 256'(0));
            end
            if (c >= 9) begin
                chk("post_abort_valid", 256'(centroid_chunk_valid_o), 256'(0));
                chk("post_abort_done", 256'(done), 256'(0));
                chk("post_abort_busy", 256'(busy), 256'(0));
                chk("post_abort_norm_rst_n", 256'(norm_rst_n_o), 256'(1));
            end
        end
        run_pass(16, 4, 0, -1, 2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_pass(int'($urandom_range(1, 40)), int'($urandom_range(1, 6)), 30, -1,
                     int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
